bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential converter that takes a packed 4-digit BCD value (0-9999) and produces the equivalent 14-bit unsigned binary value using the reverse shift/subtract-3 algorithm. It is the inverse of the team's binary-to-BCD block and sits between the digit-entry/display path (Bluetooth command digits, 7-segment setpoints) and the control logic that needs plain binary. Invalid BCD digits are detected and flagged rather than converted.

## Interface
Parameters: none; all widths are fixed.

Ports:
- CLK  in  1  100 MHz system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request a conversion; sampled only in IDLE.
- BCDIN  in  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- BINOUT  out  14  converted binary value; registered, held between conversions.
- DONE  out  1  one-cycle pulse when BINOUT/ERR are updated.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  high if the last completed request had a digit > 9.

## Operation
- Working register sr[29:0]: bcd field sr[29:14], binary field sr[13:0]; shift counter cnt[3:0].
- FSM states: IDLE, LOAD, SHIFT, CORR, DONE.
- IDLE: cnt <= 0; if START then go to LOAD, else stay in IDLE.
- LOAD: capture BCDIN. If any nibble > 9, go to DONE with the invalid flag set. Otherwise set sr <= {BCDIN, 14'b0} and go to SHIFT.
- SHIFT: sr <= {1'b0, sr[29:1]}; cnt <= cnt + 1; go to CORR.
- CORR: if cnt != 14, then for each of the four bcd nibbles in sr[29:14] independently, subtract 3 if the nibble is >= 8, and go back to SHIFT. If cnt == 14, make no correction and go to DONE.
- DONE, valid case: BINOUT <= sr[13:0]; ERR <= 0; DONE <= 1; go to IDLE.
- DONE, invalid case: BINOUT keeps its previous value; ERR <= 1; DONE <= 1; go to IDLE.
- Subtract-3 is 4-bit modulo arithmetic. It can never underflow because it only fires when the nibble is >= 8.
- On a valid conversion the bcd field is all zero at DONE. A nonzero field there is an internal error and is checked only by assertion.
- BCDIN is sampled only in LOAD. Changes on BCDIN at any other time have no effect.
- START while BUSY is ignored; it is not queued.
- START held high continuously starts back-to-back conversions, the next one from the IDLE cycle after DONE.

## Timing
- Reset values: BINOUT = 0, DONE = 0, BUSY = 0, ERR = 0, state IDLE, sr = 0, cnt = 0.
- Reset mid-conversion aborts immediately: all outputs take their reset values on the next edge, and no DONE pulse is produced.
- Let edge k be the one where START is sampled in IDLE.
- Valid input: LOAD runs at edge k+1. SHIFT/CORR pairs run at edges k+2 through k+29 (14 shifts). DONE runs at edge k+30.
- BINOUT, ERR and DONE are valid in the cycle after edge k+30, so latency is 30 cycles from the START-sampling edge.
- Invalid input: DONE pulse and ERR assert in the cycle after edge k+2.
- BUSY is high from the cycle after edge k until DONE is asserted. BUSY and DONE are both high in the DONE-pulse cycle.
- The earliest next START is sampled in the cycle where DONE is high (state is already IDLE).
- Throughput is one conversion per 31 cycles with START held high.

## Test plan
- Reset then BCDIN=16'h9999 with START pulse -> DONE exactly 30 cycles after the START edge, BINOUT=14'd9999 (14'h270F), ERR=0, BUSY low the cycle after DONE.
- Sweep BCDIN=16'h0000, 16'h0001, 16'h1234, 16'h0512 -> BINOUT = 0, 1, 1234 (14'h04D2), 512, each with ERR=0.
- After a valid 1234, apply BCDIN=16'h12A4 -> DONE 2 cycles after the START edge, ERR=1, BINOUT still 1234. A following valid 16'h0042 then gives BINOUT=42 and ERR=0.
- START pulsed again at cycle 10 of a busy conversion, with BCDIN changed to 16'h0007 -> ignored; the original result is delivered and only one DONE pulse occurs.
- RST asserted at cycle 15 of a conversion -> next cycle BINOUT=0, BUSY=0, ERR=0, and no DONE. A new START then converts correctly.
- Round trip: for bin = 0..1023, drive the team's binary-to-BCD converter and feed its BCD output into this block -> BINOUT equals bin every time, and ERR is never set.

Source files
------------

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: 4-digit packed BCD to 14-bit binary converter
// using reverse double-dabble (shift right, subtract 3 from nibbles >= 8).
module bcd_to_binary (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] BCDIN,
    output logic [13:0] BINOUT,
    output logic        DONE,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_CORR,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [29:0] sr;
    logic [3:0]  cnt;
    logic        inv;
    logic        bad_digit;

    assign bad_digit = (BCDIN[15:12] > 4'd9) ||
                       (BCDIN[11:8]  > 4'd9) ||
                       (BCDIN[7:4]   > 4'd9) ||
                       (BCDIN[3:0]   > 4'd9);

    function automatic logic [3:0] fix(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    // state register
    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = bad_digit ? S_DONE : S_SHIFT;
            S_SHIFT: state_nxt = S_CORR;
            S_CORR:  state_nxt = (cnt == 4'd14) ? S_DONE : S_SHIFT;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr     <= '0;
            cnt    <= '0;
            inv    <= 1'b0;
            BINOUT <= '0;
            DONE   <= 1'b0;
            BUSY   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            // stays high through the DONE-pulse cycle, drops in IDLE
            BUSY <= (state != S_IDLE) || START;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                end
                S_LOAD: begin
                    inv <= bad_digit;
                    if (!bad_digit)
                        sr <= {BCDIN, 14'b0};
                end
                S_SHIFT: begin
                    sr  <= {1'b0, sr[29:1]};
                    cnt <= cnt + 4'd1;
                end
                S_CORR: begin
                    if (cnt != 4'd14)
                        sr[29:14] <= {fix(sr[29:26]), fix(sr[25:22]),
                                      fix(sr[21:18]), fix(sr[17:14])};
                end
                S_DONE: begin
                    DONE <= 1'b1;
                    if (inv) begin
                        ERR <= 1'b1;
                    end else begin
                        BINOUT <= sr[13:0];
                        ERR    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // bcd field must be fully drained at the end of a valid conversion
    always @(posedge CLK) begin
        if (!RST && state == S_DONE && !inv)
            assert (sr[29:14] == 16'd0);
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed vectors with a scoreboard queue
// checked by an independent DONE monitor.
module tb_bcd_to_binary;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [15:0] BCDIN;
    logic [13:0] BINOUT;
    logic        DONE;
    logic        BUSY;
    logic        ERR;

    typedef struct {
        int bin;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    bcd_to_binary dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .BCDIN (BCDIN),
        .BINOUT(BINOUT),
        .DONE  (DONE),
        .BUSY  (BUSY),
        .ERR   (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] bin2bcd(input int b);
        logic [15:0] r;
        r[15:12] = 4'((b / 1000) % 10);
        r[11:8]  = 4'((b / 100) % 10);
        r[7:4]   = 4'((b / 10) % 10);
        r[3:0]   = 4'(b % 10);
        return r;
    endfunction

    // scoreboard monitor
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE with empty queue");
            end else begin
                e = exp_q.pop_front();
                check("binout", int'(BINOUT), e.bin);
                check("err", int'(ERR), int'(e.err));
            end
        end
    end

    task automatic conv(input logic [15:0] bcd, input int eb,
                        input bit ee, input int lat, input string nm);
        int n;
        exp_q.push_back('{eb, ee});
        BCDIN = bcd;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        n = 0;
        while (n < 60) begin
            @(posedge CLK);
            n++;
            #1;
            if (n == 1)
                BCDIN = 16'h5555;
            @(negedge CLK);
            if (DONE === 1'b1)
                break;
        end
        check({nm, "_lat"}, n, lat);
        check({nm, "_busy_done"}, int'(BUSY), 1);
        @(negedge CLK);
        check({nm, "_busy_after"}, int'(BUSY), 0);
    endtask

    initial begin
        int d0;
        RST   = 1'b1;
        START = 1'b0;
        BCDIN = 16'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_binout", int'(BINOUT), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_err", int'(ERR), 0);
        RST = 1'b0;
        @(negedge CLK);

        conv(16'h9999, 9999, 1'b0, 30, "c9999");
        conv(16'h0000, 0, 1'b0, 30, "c0000");
        conv(16'h0001, 1, 1'b0, 30, "c0001");
        conv(16'h1234, 1234, 1'b0, 30, "c1234");
        conv(16'h0512, 512, 1'b0, 30, "c0512");
        conv(16'h1234, 1234, 1'b0, 30, "c1234b");
        conv(16'h12A4, 1234, 1'b1, 2, "inv12a4");
        conv(16'h0042, 42, 1'b0, 30, "c0042");

        // START while busy is ignored
        exp_q.push_back('{512, 1'b0});
        d0 = done_cnt;
        BCDIN = 16'h0512;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (9) @(posedge CLK);
        #1 START = 1'b1;
        BCDIN = 16'h0007;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (40) @(negedge CLK);
        check("busy_start_dones", done_cnt - d0, 1);

        conv(16'h9F00, 512, 1'b1, 2, "inv9f00");

        // reset mid-conversion
        d0 = done_cnt;
        BCDIN = 16'h9999;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (14) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("abort_binout", int'(BINOUT), 0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_err", int'(ERR), 0);
        check("abort_done", int'(DONE), 0);
        repeat (40) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 0);

        conv(16'h0777, 777, 1'b0, 30, "c0777");

        for (int b = 0; b < 1024; b++)
            conv(bin2bcd(b), b, 1'b0, 30, "rt");

        repeat (5) @(negedge CLK);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
